gcd_engine: RTL

//  Parametrised, self-sequenced Euclid GCD engine: second-generation replacement for the ALU-driven GCD datapath.
//  Own FSM and sequential modulo unit; no external controller needed. Valid/ack handshake, abort, optional

---
 rtl/gcd_engine_pkg.sv | 15 +
 rtl/gcd_engine_mod_seq.sv | 82 ++++++++
 rtl/gcd_engine.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gcd_engine_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding and parameter defaults.
package gcd_engine_pkg;

  localparam int unsigned GCD_WIDTH_DEF  = 16;
  localparam int unsigned GCD_ITER_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORDER,
    ST_CHECK,
    ST_MOD_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/gcd_engine_mod_seq.sv
// Sequential restoring shift-subtract remainder unit: one dividend bit per cycle,
// done_o asserted in the WIDTH-th cycle after the start edge.
module mod_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  function automatic logic [WIDTH-1:0] rstep(input logic [WIDTH-1:0] r,
                                             input logic             bit_in,
                                             input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    t = {r, bit_in};
    if (t >= {1'b0, d}) t = t - {1'b0, d};
    return t[WIDTH-1:0];
  endfunction

  // The start edge already performs the first step, so WIDTH-1 further steps remain.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (clr_i) begin
      rem_d  = '0;
      quo_d  = '0;
      div_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b0;
    end else if (start_i) begin
      rem_d  = rstep('0, dividend_i[WIDTH-1], divisor_i);
      quo_d  = dividend_i << 1;
      div_d  = divisor_i;
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        rem_d = rstep(rem_q, quo_q[WIDTH-1], div_q);
        quo_d = quo_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign rem_o  = rem_q;
  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/gcd_engine.sv
// Self-sequenced Euclid GCD engine with valid/ack handshake, abort, optional signed
// operands and a saturating count of modulo operations.
module gcd_engine
  import gcd_engine_pkg::*;
#(
  parameter int unsigned WIDTH  = GCD_WIDTH_DEF,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned ITER_W = GCD_ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIDTH-1:0]  zahl1_i,
  input  logic [WIDTH-1:0]  zahl2_i,
  input  logic              ack_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [WIDTH-1:0]  ergebnis_o,
  output logic [ITER_W-1:0] iter_o
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ITER_W-1:0] iter_out_q, iter_out_d;

  logic              mod_start;
  logic              mod_clr;
  logic [WIDTH-1:0]  mod_rem;
  logic              mod_done;

  // Negating the most negative value wraps to 2^(WIDTH-1), its exact magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    if (SIGNED && x[WIDTH-1]) return -x;
    return x;
  endfunction

  mod_seq #(.WIDTH(WIDTH)) u_mod_seq (
    .clk        (clk),
    .rst_ni     (rst_ni),
    .clr_i      (mod_clr),
    .start_i    (mod_start),
    .dividend_i (a_q),
    .divisor_i  (b_q),
    .rem_o      (mod_rem),
    .done_o     (mod_done)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    iter_d     = iter_q;
    res_d      = res_q;
    iter_out_d = iter_out_q;
    mod_start  = 1'b0;
    mod_clr    = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      mod_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_d     = mag(zahl1_i);
            b_d     = mag(zahl2_i);
            iter_d  = '0;
            state_d = ST_ORDER;
          end
        end
        ST_ORDER: begin
          if (b_q > a_q) begin
            a_d = b_q;
            b_d = a_q;
          end
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (b_q == '0) begin
            res_d      = a_q;
            iter_out_d = iter_q;
            state_d    = ST_DONE;
          end else begin
            mod_start = 1'b1;
            state_d   = ST_MOD_WAIT;
          end
        end
        ST_MOD_WAIT: begin
          if (mod_done) begin
            a_d     = b_q;
            b_d     = mod_rem;
            iter_d  = (&iter_q) ? iter_q : iter_q + ITER_W'(1);
            state_d = ST_CHECK;
          end
        end
        ST_DONE: begin
          if (ack_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      iter_q     <= '0;
      res_q      <= '0;
      iter_out_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      iter_q     <= iter_d;
      res_q      <= res_d;
      iter_out_q <= iter_out_d;
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign ergebnis_o = res_q;
  assign iter_o     = iter_out_q;

endmodule
